button_event: RTL
=================

# button_event

Converts the debounced switch level from the debouncer into single-cycle event pulses: press, release, single click, double click and long press. It sits directly downstream of the debouncer, shares its clock, and feeds the control logic that acts on button gestures. All outputs are registered, and at most one gesture event (click, double click or long) is reported per gesture.

## Interface
- `LONG_CYCLES`, default 8: number of consecutive cycles the level must stay high after a press before `long_o` fires. Legal range is 2 or more.
- `DCLICK_CYCLES`, default 4: length of the window after a release in which a second press counts as a double click. Legal range is 1 or more.
- `clk_i`, input, 1 bit: the only clock. All logic is rising-edge.
- `rst_i`, input, 1 bit: synchronous, active-low reset.
- `db_i`, input, 1 bit: debounced switch level from the debouncer output, already synchronous to `clk_i`.
- `press_o`, output, 1 bit: one-cycle pulse on every rising edge of the level.
- `release_o`, output, 1 bit: one-cycle pulse on every falling edge of the level.
- `click_o`, output, 1 bit: one-cycle pulse when a single click completes.
- `dclick_o`, output, 1 bit: one-cycle pulse when a double click completes.
- `long_o`, output, 1 bit: one-cycle pulse when a long press is detected.
- `held_o`, output, 1 bit: registered level, high while the FSM is in PRESSED, SECOND or LONG_HELD.

## Operation
- The counter width is `$clog2(max(LONG_CYCLES, DCLICK_CYCLES)) + 1`. The counter never wraps: it is cleared on every state entry and saturates at its terminal compare value.
- Reset: `rst_i` is sampled low at a rising edge. Effects:
  - state becomes IDLE and the counter becomes 0;
  - all outputs are 0 after that edge;
  - this holds mid-gesture, with no pending event emitted.
- FSM transitions. In every case, if no listed condition holds the state is unchanged.
  - **IDLE**:
    - `db_i`=1 gives `press_o`, clears the counter and goes to PRESSED.
  - **PRESSED**:
    - `db_i`=0 gives `release_o`, clears the counter and goes to WAIT.
    - Otherwise, if the counter equals `LONG_CYCLES`-1, gives `long_o` and goes to LONG_HELD.
    - Otherwise the counter increments.
  - **LONG_HELD**:
    - `db_i`=0 gives `release_o` and goes to IDLE. No click is reported.
  - **WAIT**:
    - `db_i`=1 gives `press_o`, clears the counter and goes to SECOND.
    - Otherwise, if the counter equals `DCLICK_CYCLES`-1, gives `click_o` and goes to IDLE.
    - Otherwise the counter increments.
  - **SECOND**:
    - `db_i`=0 gives `release_o` and `dclick_o` in the same cycle and goes to IDLE.
    - Otherwise, if the counter equals `LONG_CYCLES`-1, gives `click_o` and `long_o` in the same cycle and goes to LONG_HELD. This reports the first tap as a click followed by a long press.
    - Otherwise the counter increments.
- Simultaneous-event priority: a `db_i` level change always beats a counter terminal count in the same cycle.
  - A release sampled on the cycle the long count would fire means no `long_o`.
  - A press sampled on the last cycle of the double-click window means a double click is still possible, and no `click_o` is emitted.
- `held_o` is a registered copy of "state is PRESSED, SECOND or LONG_HELD".
- An upstream glitch of a single cycle is handled normally, as a press followed by a release. Debouncing is not this block's job.

## Timing
- Latency from the input to a press or release pulse is one edge.
  - If `db_i` is first sampled high at edge k, `press_o` is high for exactly the cycle after edge k.
  - `held_o` rises at edge k.
- Long press: `long_o` is asserted after edge k+`LONG_CYCLES`, provided `db_i` was sampled high at every edge from k to k+`LONG_CYCLES`.
- Release window: with the release sampled at edge r, a single click gives `click_o` after edge r+`DCLICK_CYCLES`, provided `db_i` was sampled low at edges r to r+`DCLICK_CYCLES`.
- Second press: a second press sampled at any edge from r+1 to r+`DCLICK_CYCLES` enters SECOND.
- Every output pulse is exactly one cycle wide. No output is combinational from `db_i`.
- Back-to-back gestures are supported: a press sampled on the edge immediately after a `click_o` or `dclick_o` edge starts a new gesture.

## Test plan
All scenarios use `LONG_CYCLES`=8 and `DCLICK_CYCLES`=4.
- **Reset:** hold `rst_i`=0 for 2 cycles while `db_i`=1, then release. Required: all outputs 0 during reset; `press_o` pulses one cycle after the first edge with `rst_i`=1. Assert reset again mid-PRESSED: no `long_o` and no `release_o` follow.
- **Single click:** `db_i` high for 3 edges, then low. Required: `press_o` at edge k, `release_o` at edge k+3, `click_o` at edge k+7. `long_o` and `dclick_o` never pulse.
- **Double click:** high for 2 edges, low for 2, high for 2, low. Required: two `press_o` pulses and two `release_o` pulses, with `dclick_o` coincident with the second `release_o`. No `click_o`.
- **Long press:** high for 20 edges. Required: `long_o` at edge k+8; `release_o` on the fall; no `click_o`. Boundary case: release sampled at edge k+8 gives `release_o` and no `long_o`.
- **Window boundary:** second press sampled at exactly edge r+4 leads to a double click. Second press sampled at edge r+5 gives `click_o` at r+4 and then a new `press_o` at r+5.
- **Random soak:** drive 1000 random high and low intervals in the range 1–12 cycles against a reference model. Required:
  - event counts match the model;
  - `click_o` + `dclick_o` + `long_o` ≤ 1 per gesture, except the defined SECOND-long case where `click_o` and `long_o` pulse together.

Source files
------------

// File: rtl/button_event.sv
// Gesture decoder downstream of the debouncer: turns a clean switch level into
// registered one-cycle press/release/click/double-click/long-press pulses.
module button_event #(
  parameter int unsigned LONG_CYCLES   = 8,
  parameter int unsigned DCLICK_CYCLES = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic db_i,
  output logic press_o,
  output logic release_o,
  output logic click_o,
  output logic dclick_o,
  output logic long_o,
  output logic held_o
);

  localparam int unsigned MAX_C = (LONG_CYCLES > DCLICK_CYCLES) ? LONG_CYCLES : DCLICK_CYCLES;
  localparam int unsigned CW    = $clog2(MAX_C) + 1;
  localparam logic [CW-1:0] LONG_TC = CW'(LONG_CYCLES - 1);
  localparam logic [CW-1:0] DCLK_TC = CW'(DCLICK_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRESSED,
    S_WAIT,
    S_SECOND,
    S_LONG_HELD
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            press_q, press_d;
  logic            release_q, release_d;
  logic            click_q, click_d;
  logic            dclick_q, dclick_d;
  logic            long_q, long_d;
  logic            held_q, held_d;

  // A level change on db_i always takes precedence over a terminal count.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    click_d   = 1'b0;
    dclick_d  = 1'b0;
    long_d    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (db_i) begin
          press_d = 1'b1;
          cnt_d   = '0;
          state_d = S_PRESSED;
        end
      end
      S_PRESSED: begin
        if (!db_i) begin
          release_d = 1'b1;
          cnt_d     = '0;
          state_d   = S_WAIT;
        end else if (cnt_q == LONG_TC) begin
          long_d  = 1'b1;
          cnt_d   = '0;
          state_d = S_LONG_HELD;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_LONG_HELD: begin
        if (!db_i) begin
          release_d = 1'b1;
          cnt_d     = '0;
          state_d   = S_IDLE;
        end
      end
      S_WAIT: begin
        if (db_i) begin
          press_d = 1'b1;
          cnt_d   = '0;
          state_d = S_SECOND;
        end else if (cnt_q == DCLK_TC) begin
          click_d = 1'b1;
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_SECOND: begin
        if (!db_i) begin
          release_d = 1'b1;
          dclick_d  = 1'b1;
          cnt_d     = '0;
          state_d   = S_IDLE;
        end else if (cnt_q == LONG_TC) begin
          // First tap is reported as a click together with the long press.
          click_d = 1'b1;
          long_d  = 1'b1;
          cnt_d   = '0;
          state_d = S_LONG_HELD;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
    held_d = (state_d == S_PRESSED) || (state_d == S_SECOND) || (state_d == S_LONG_HELD);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      click_q   <= 1'b0;
      dclick_q  <= 1'b0;
      long_q    <= 1'b0;
      held_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      press_q   <= press_d;
      release_q <= release_d;
      click_q   <= click_d;
      dclick_q  <= dclick_d;
      long_q    <= long_d;
      held_q    <= held_d;
    end
  end

  assign press_o   = press_q;
  assign release_o = release_q;
  assign click_o   = click_q;
  assign dclick_o  = dclick_q;
  assign long_o    = long_q;
  assign held_o    = held_q;

endmodule
